// File: rtl/mvm_flex_if.sv
// Command, load-data and result-stream signals of the mvm_flex matrix-vector engine.
// master drives commands and out_ready; slave is the engine.
interface mvm_flex_if #(
  parameter int T  = 8,
  parameter int OW = 16
);
  logic                 loadMatrix;
  logic                 loadVector;
  logic                 start;
  logic signed [T-1:0]  data_in;
  logic                 out_ready;
  logic signed [OW-1:0] data_out;
  logic                 out_valid;
  logic                 done;
  logic                 busy;
  logic                 cmd_err;

  modport master (
    output loadMatrix, loadVector, start, data_in, out_ready,
    input  data_out, out_valid, done, busy, cmd_err
  );

  modport slave (
    input  loadMatrix, loadVector, start, data_in, out_ready,
    output data_out, out_valid, done, busy, cmd_err
  );
endinterface

// File: rtl/mvm_flex.sv
// Matrix-vector multiplier y = A*x with P row MACs per cycle and a ready/valid result stream.
// state     | meaning
// IDLE      | waiting for loadMatrix / loadVector / start
// LOAD_M    | writing M*N matrix words, row-major, one per cycle
// LOAD_V    | writing N vector words, one per cycle
// COMPUTE   | N MAC cycles per group of P rows, M/P groups
// OUTPUT    | streaming y[0..M-1] under out_ready
module mvm_flex #(
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int T   = 8,
  parameter int P   = 1,
  parameter int OW  = 2*T,
  parameter int SAT = 0
) (
  input  logic      clk,
  input  logic      reset,
  mvm_flex_if.slave bus
);
  localparam int G  = M / P;
  localparam int AW = 2*T + $clog2(N);
  localparam int XW = (AW > OW) ? AW : OW;
  localparam int IW = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int YW = (M > 1) ? $clog2(M) : 1;

  generate
    if (M % P != 0) begin : g_bad_p
      $error("mvm_flex: M must be divisible by P");
    end
  endgenerate

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_M  = 3'd1;
  localparam logic [2:0] S_LOAD_V  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]           state;
  logic [IW-1:0]        ld_idx;
  logic [KW-1:0]        k_idx;
  logic [GW-1:0]        grp;
  logic [YW-1:0]        out_idx;
  logic                 done_q;
  logic                 cmd_err_q;
  logic signed [T-1:0]  mat   [M*N];
  logic signed [T-1:0]  vec   [N];
  logic signed [AW-1:0] acc   [P];
  logic [OW-1:0]        y_mem [M];

  logic signed [T-1:0]   a_op [P];
  logic signed [2*T-1:0] prod [P];
  logic signed [AW-1:0]  sum  [P];
  logic [OW-1:0]         conv [P];

  // Clamp or wrap a full-precision sum into the OW-bit output word.
  function automatic logic [OW-1:0] to_ow(input logic signed [AW-1:0] v);
    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    ext = XW'(v);
    hi  = XW'({1'b0, {(OW-1){1'b1}}});
    lo  = ~hi;
    if (SAT != 0) begin
      if (ext > hi) return hi[OW-1:0];
      if (ext < lo) return lo[OW-1:0];
    end
    return ext[OW-1:0];
  endfunction

  always_comb begin
    for (int p = 0; p < P; p++) begin
      a_op[p] = mat[IW'((int'(grp) * P + p) * N + int'(k_idx))];
      prod[p] = (2*T)'(a_op[p]) * (2*T)'(vec[k_idx]);
      sum[p]  = acc[p] + AW'(prod[p]);
      conv[p] = to_ow(sum[p]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ld_idx    <= '0;
      k_idx     <= '0;
      grp       <= '0;
      out_idx   <= '0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      for (int i = 0; i < M*N; i++) mat[i]   <= '0;
      for (int i = 0; i < N; i++)   vec[i]   <= '0;
      for (int i = 0; i < P; i++)   acc[i]   <= '0;
      for (int i = 0; i < M; i++)   y_mem[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      cmd_err_q <= (state != S_IDLE) && (bus.loadMatrix || bus.loadVector || bus.start);
      case (state)
        S_IDLE: begin
          if (bus.loadMatrix) begin
            state  <= S_LOAD_M;
            ld_idx <= '0;
          end else if (bus.loadVector) begin
            state  <= S_LOAD_V;
            ld_idx <= '0;
          end else if (bus.start) begin
            state <= S_COMPUTE;
            grp   <= '0;
            k_idx <= '0;
            for (int p = 0; p < P; p++) acc[p] <= '0;
          end
        end
        S_LOAD_M: begin
          mat[ld_idx] <= bus.data_in;
          if (ld_idx == IW'(M*N - 1)) begin
            state  <= S_IDLE;
            ld_idx <= '0;
          end else begin
            ld_idx <= ld_idx + IW'(1);
          end
        end
        S_LOAD_V: begin
          vec[ld_idx[KW-1:0]] <= bus.data_in;
          if (ld_idx == IW'(N - 1)) begin
            state  <= S_IDLE;
            ld_idx <= '0;
          end else begin
            ld_idx <= ld_idx + IW'(1);
          end
        end
        S_COMPUTE: begin
          if (k_idx == KW'(N - 1)) begin
            // Last column of this group: retire P finished rows and clear for the next group.
            k_idx <= '0;
            for (int p = 0; p < P; p++) begin
              y_mem[YW'(int'(grp) * P + p)] <= conv[p];
              acc[p] <= '0;
            end
            if (grp == GW'(G - 1)) begin
              state   <= S_OUTPUT;
              grp     <= '0;
              out_idx <= '0;
            end else begin
              grp <= grp + GW'(1);
            end
          end else begin
            k_idx <= k_idx + KW'(1);
            for (int p = 0; p < P; p++) acc[p] <= sum[p];
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            if (out_idx == YW'(M - 1)) begin
              state   <= S_IDLE;
              out_idx <= '0;
              done_q  <= 1'b1;
            end else begin
              out_idx <= out_idx + YW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state == S_OUTPUT);
  assign bus.data_out  = (state == S_OUTPUT) ? y_mem[out_idx] : '0;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.cmd_err   = cmd_err_q;
endmodule
